xdma_stream_packer: RTL and testbench
=====================================

XDMA_STREAM_PACKER -- requirements
Module: xdma_stream_packer

Interface
REQ-001 Parameter DATA_WIDTH, default 1000: width of one difftest batch word in bits; SHALL be a multiple of 8.
REQ-002 Parameter AXIS_DATA_WIDTH, default 512: AXI-stream beat width in bits; SHALL be a multiple of 8.
REQ-003 Parameter DEPTH, default 8: buffer entries; SHALL be a power of two, ≥2.
REQ-004 Parameter STALL_THRESHOLD, default 2: free-entry count at or below which the core is stalled.
REQ-005 Parameter PKTS_PER_XFER, default 1: entries per AXI-stream transfer (tlast period).
REQ-006 clock  input  1  sole clock.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 difftest_data  input  DATA_WIDTH  batch word from the core.
REQ-009 difftest_enable  input  1  difftest_data valid this cycle.
REQ-010 core_clock_enable  output  1  high allows the core clock to tick.
REQ-011 axi_tdata  output  AXIS_DATA_WIDTH  stream data.
REQ-012 axi_tkeep  output  AXIS_DATA_WIDTH/8  byte enables.
REQ-013 axi_tlast  output  1  last beat of a transfer.
REQ-014 axi_tvalid  output  1  beat valid.
REQ-015 axi_tready  input  1  sink ready.
REQ-016 overflow  output  1  sticky; an enabled word arrived while full.
REQ-017 drop_count  output  32  number of dropped words, saturating.

Function
REQ-018 BEATS = ceil(DATA_WIDTH/AXIS_DATA_WIDTH); LAST_BYTES = (DATA_WIDTH/8) - (BEATS-1)*(AXIS_DATA_WIDTH/8).
REQ-019 Capture: when difftest_enable=1 and the buffer is not full, difftest_data is written at the tail in the same clock edge.
REQ-020 Enabled word while full: word discarded, overflow set, drop_count incremented (saturating at 0xFFFFFFFF).
REQ-021 core_clock_enable = (free entries > STALL_THRESHOLD), registered, so it updates 1 cycle after the occupancy change.
REQ-022 Serialiser FSM states: IDLE and SEND.
REQ-023 IDLE -> SEND when the buffer is non-empty; beat index cleared to 0.
REQ-024 In SEND, axi_tvalid=1 and axi_tdata = head entry bits [beat*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH], zero-padded above DATA_WIDTH.
REQ-025 axi_tkeep is all ones except on beat BEATS-1, where only the low LAST_BYTES bits are set.
REQ-026 A beat advances only on axi_tvalid & axi_tready; tdata, tkeep and tlast SHALL hold stable while tvalid=1 and tready=0.
REQ-027 On acceptance of beat BEATS-1: head popped, the per-transfer entry counter is incremented, and the FSM stays in SEND if entries remain, else returns to IDLE.
REQ-028 axi_tlast=1 only on beat BEATS-1 of the entry that makes the per-transfer count reach PKTS_PER_XFER; the counter then wraps to 0.
REQ-029 Simultaneous push and pop in one cycle: occupancy unchanged; the push is accepted even when the buffer was full before the pop.
REQ-030 Pointers are log2(DEPTH)+1 bits; full/empty are decoded from the MSB and the equality of the low bits, and wrap-around is modular.
REQ-031 BEATS=1 is legal; every beat is then the last beat of an entry.

Reset
REQ-032 While reset=0: FSM=IDLE, pointers, beat index and transfer counter = 0, axi_tvalid=0, axi_tlast=0, axi_tkeep=0, axi_tdata=0, core_clock_enable=1, overflow=0, drop_count=0.
REQ-033 Reset asserted in the middle of a transfer abandons it immediately; no partial beat is emitted after release.
REQ-034 Buffer storage is not reset.

Structure
REQ-035 A shared package holds the BEATS and LAST_BYTES derivation functions and the FSM state enum.
REQ-036 One sub-module, xdma_sync_fifo (parameters WIDTH and DEPTH; outputs full, empty and count), holds the buffer; the serialiser and the stall logic live in xdma_stream_packer.

Verification
REQ-037 Defaults, one word 0xAB..AB with tready=1 -> 2 beats; beat 1 tkeep=0x1FFFFFFFFFFFFFFF (61 bytes); tlast on beat 1.
REQ-038 PKTS_PER_XFER=3, 3 words -> 6 beats; tlast only on beat 6.
REQ-039 tready=0, 6 words pushed -> core_clock_enable drops to 0 one cycle after count reaches 6; the next 2 words are accepted, a 9th gives overflow=1, drop_count=1.
REQ-040 Buffer full, push and pop on the same edge -> count stays 8, no drop.
REQ-041 tready toggling 1/0 each cycle -> tdata and tkeep stable during stalls; 10 words arrive in order, covering pointer wrap.
REQ-042 Reset asserted during beat 0 -> tvalid=0 on the next edge; after release, count=0 and core_clock_enable=1.

Source files
------------

// File: rtl/xdma_stream_packer_pkg.sv
// xdma_stream_packer_pkg: beat/last-byte derivations and serialiser state type shared by the packer
package xdma_stream_packer_pkg;
  typedef enum logic {ST_IDLE = 1'b0, ST_SEND = 1'b1} state_e;
  function automatic int calc_beats(input int dw, input int aw);
    return (dw + aw - 1) / aw;
  endfunction
  function automatic int calc_last_bytes(input int dw, input int aw);
    return dw / 8 - (calc_beats(dw, aw) - 1) * (aw / 8);
  endfunction
endpackage

// File: rtl/xdma_sync_fifo.sv
// xdma_sync_fifo: pointer-based sync fifo (push/wdata in; pop/rdata out; full, empty, count status); push allowed while full if popping
module xdma_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic wr_en, rd_en;
  always_comb begin
    empty = wr_q == rd_q;
    full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    rd_en = pop & ~empty;
    wr_en = push & (~full | rd_en);
    wr_d  = wr_q + {{AW{1'b0}}, wr_en};
    rd_d  = rd_q + {{AW{1'b0}}, rd_en};
    count = wr_q - rd_q;
    rdata = mem_q[rd_q[AW-1:0]];
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  always_ff @(posedge clock)
    if (wr_en) mem_q[wr_q[AW-1:0]] <= wdata;
endmodule

// File: rtl/xdma_stream_packer.sv
// xdma_stream_packer: buffers difftest words and serialises them onto AXI-stream (difftest in, axi_t* out, core stall, overflow/drop stats)
module xdma_stream_packer
  import xdma_stream_packer_pkg::*;
#(
  parameter int DATA_WIDTH      = 1000,
  parameter int AXIS_DATA_WIDTH = 512,
  parameter int DEPTH           = 8,
  parameter int STALL_THRESHOLD = 2,
  parameter int PKTS_PER_XFER   = 1
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [DATA_WIDTH-1:0]        difftest_data,
  input  logic                         difftest_enable,
  output logic                         core_clock_enable,
  output logic [AXIS_DATA_WIDTH-1:0]   axi_tdata,
  output logic [AXIS_DATA_WIDTH/8-1:0] axi_tkeep,
  output logic                         axi_tlast,
  output logic                         axi_tvalid,
  input  logic                         axi_tready,
  output logic                         overflow,
  output logic [31:0]                  drop_count
);
  localparam int BEATS      = calc_beats(DATA_WIDTH, AXIS_DATA_WIDTH);
  localparam int LAST_BYTES = calc_last_bytes(DATA_WIDTH, AXIS_DATA_WIDTH);
  localparam int KW         = AXIS_DATA_WIDTH / 8;
  localparam int AW         = $clog2(DEPTH);
  localparam int BW         = BEATS > 1 ? $clog2(BEATS) : 1;
  localparam int XW         = PKTS_PER_XFER > 1 ? $clog2(PKTS_PER_XFER) : 1;
  localparam int PW         = BEATS * AXIS_DATA_WIDTH;
  localparam logic [KW-1:0] LAST_KEEP = {KW{1'b1}} >> (KW - LAST_BYTES);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
  localparam logic [XW-1:0] LAST_XFER = XW'(PKTS_PER_XFER - 1);
  localparam logic [AW:0]   ONE       = (AW + 1)'(1);
  state_e state_q, state_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [XW-1:0] xfer_q, xfer_d;
  logic cce_q, cce_d, ovf_q, ovf_d;
  logic [31:0] drop_q, drop_d;
  logic full, empty, send, last_beat, accept, pop, push, drop;
  logic [AW:0] count;
  logic [DATA_WIDTH-1:0] head;
  logic [PW-1:0] padded;
  xdma_sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .wdata (difftest_data),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );
  always_comb begin
    send      = state_q == ST_SEND;
    last_beat = beat_q == LAST_BEAT;
    accept    = send & axi_tready;
    pop       = accept & last_beat;
    push      = difftest_enable & (~full | pop);
    drop      = difftest_enable & full & ~pop;
    padded    = '0;
    padded[DATA_WIDTH-1:0] = head;
    axi_tvalid = send;
    axi_tdata  = send ? padded[int'(beat_q)*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH] : '0;
    axi_tkeep  = !send ? '0 : last_beat ? LAST_KEEP : '1;
    axi_tlast  = send & last_beat & (xfer_q == LAST_XFER);
    state_d = state_q;
    beat_d  = beat_q;
    xfer_d  = xfer_q;
    if (!send) begin
      state_d = empty ? ST_IDLE : ST_SEND;
      beat_d  = '0;
    end else if (accept) begin
      beat_d = last_beat ? '0 : beat_q + 1'b1;
      if (last_beat) begin
        xfer_d  = xfer_q == LAST_XFER ? '0 : xfer_q + 1'b1;
        // count still includes the head being popped this cycle
        state_d = (count != ONE || push) ? ST_SEND : ST_IDLE;
      end
    end
    cce_d  = (DEPTH - int'(count)) > STALL_THRESHOLD;
    ovf_d  = ovf_q | drop;
    drop_d = (drop && drop_q != '1) ? drop_q + 32'd1 : drop_q;
    core_clock_enable = cce_q;
    overflow          = ovf_q;
    drop_count        = drop_q;
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state_q <= ST_IDLE;
      beat_q  <= '0;
      xfer_q  <= '0;
      cce_q   <= 1'b1;
      ovf_q   <= 1'b0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      xfer_q  <= xfer_d;
      cce_q   <= cce_d;
      ovf_q   <= ovf_d;
      drop_q  <= drop_d;
    end
endmodule

// File: tb/tb_xdma_stream_packer.sv
// tb_xdma_stream_packer: table, directed and random checks of the packer against a queue-based reference model
module tb_xdma_stream_packer;
  localparam int DW = 1000, AXW = 512, KW = 64, BEATS = 2, DEPTH = 8, THR = 2;
  typedef struct {
    int n;
    int gap;
    int mode;
    int beats;
    int tl;
    int tl3;
  } row_t;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic [DW-1:0] difftest_data = '0;
  logic difftest_enable = 1'b0;
  logic axi_tready = 1'b0;
  logic cce, tlast, tvalid, ovf, cce3, tlast3, tvalid3, ovf3;
  logic [AXW-1:0] tdata, tdata3;
  logic [KW-1:0] tkeep, tkeep3;
  logic [31:0] drops, drops3;
  int errors = 0, checks = 0, rmode = 0;
  logic tog = 1'b0;
  logic [DW-1:0] mq [$];
  int mbeat = 0, mx = 0, last_size = 0, exp_drops = 0;
  logic exp_ovf = 1'b0;
  int nb = 0, ntl = 0, ntl3 = 0;
  logic prev_stall = 1'b0;
  logic [AXW-1:0] prev_data = '0;
  logic [KW-1:0] prev_keep = '0;
  row_t rows [5];
  always #5 clock = ~clock;
  xdma_stream_packer u_dut (
    .clock(clock), .reset(reset), .difftest_data(difftest_data), .difftest_enable(difftest_enable),
    .core_clock_enable(cce), .axi_tdata(tdata), .axi_tkeep(tkeep), .axi_tlast(tlast),
    .axi_tvalid(tvalid), .axi_tready(axi_tready), .overflow(ovf), .drop_count(drops)
  );
  xdma_stream_packer #(.PKTS_PER_XFER(3)) u_dut3 (
    .clock(clock), .reset(reset), .difftest_data(difftest_data), .difftest_enable(difftest_enable),
    .core_clock_enable(cce3), .axi_tdata(tdata3), .axi_tkeep(tkeep3), .axi_tlast(tlast3),
    .axi_tvalid(tvalid3), .axi_tready(axi_tready), .overflow(ovf3), .drop_count(drops3)
  );
  task automatic chk(input string name, input logic [1023:0] act, input logic [1023:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask
  function automatic logic [AXW-1:0] exp_slice(input logic [DW-1:0] w, input int b);
    logic [1023:0] p;
    p = {24'b0, w};
    return p[b*AXW +: AXW];
  endfunction
  function automatic logic [KW-1:0] exp_keep(input int b);
    logic [KW-1:0] k;
    int n;
    n = DW / 8 - b * KW;
    if (n > KW) n = KW;
    for (int i = 0; i < KW; i++) k[i] = i < n;
    return k;
  endfunction
  function automatic logic [DW-1:0] rand_word();
    logic [1023:0] w;
    for (int i = 0; i < 32; i++) w[i*32 +: 32] = $urandom;
    return w[DW-1:0];
  endfunction
  always @(negedge clock) begin
    logic pop;
    if (!reset) begin
      chk("rst_tvalid", tvalid, 0);
      chk("rst_tdata", tdata, 0);
      chk("rst_tkeep", tkeep, 0);
      chk("rst_tlast", tlast, 0);
      chk("rst_cce", cce, 1);
      chk("rst_overflow", ovf, 0);
      chk("rst_drop_count", drops, 0);
      chk("rst_tvalid3", tvalid3, 0);
      mq.delete();
      mbeat = 0;
      mx = 0;
      last_size = 0;
      exp_drops = 0;
      exp_ovf = 1'b0;
      prev_stall = 1'b0;
    end else begin
      chk("cce", cce, (DEPTH - last_size) > THR);
      chk("cce3", cce3, (DEPTH - last_size) > THR);
      chk("overflow", ovf, exp_ovf);
      chk("overflow3", ovf3, exp_ovf);
      chk("drop_count", drops, exp_drops);
      chk("drop_count3", drops3, exp_drops);
      chk("no_spurious", tvalid && mq.size() == 0, 0);
      chk("no_spurious3", tvalid3 && mq.size() == 0, 0);
      if (prev_stall) begin
        chk("hold_valid", tvalid, 1);
        chk("hold_data", tdata, prev_data);
        chk("hold_keep", tkeep, prev_keep);
      end
      pop = 1'b0;
      if (tvalid && axi_tready && mq.size() > 0) begin
        chk("tdata", tdata, exp_slice(mq[0], mbeat));
        chk("tkeep", tkeep, exp_keep(mbeat));
        chk("tlast", tlast, mbeat == BEATS - 1);
        chk("tvalid3", tvalid3, 1);
        chk("tdata3", tdata3, exp_slice(mq[0], mbeat));
        chk("tkeep3", tkeep3, exp_keep(mbeat));
        chk("tlast3", tlast3, mbeat == BEATS - 1 && mx == 2);
        nb++;
        ntl += int'(tlast);
        ntl3 += int'(tlast3);
        if (mbeat == BEATS - 1) begin
          pop = 1'b1;
          mbeat = 0;
          mx = (mx + 1) % 3;
        end else mbeat++;
      end
      last_size = mq.size();
      if (difftest_enable) begin
        if (mq.size() < DEPTH || pop) mq.push_back(difftest_data);
        else begin
          exp_drops++;
          exp_ovf = 1'b1;
        end
      end
      if (pop) void'(mq.pop_front());
      prev_stall = tvalid && !axi_tready;
      prev_data = tdata;
      prev_keep = tkeep;
    end
  end
  task automatic cyc(input logic en, input logic [DW-1:0] d);
    difftest_enable = en;
    difftest_data = d;
    tog = ~tog;
    axi_tready = rmode == 0 ? 1'b1 : rmode == 1 ? tog : rmode == 2 ? 1'($urandom_range(0, 1)) : 1'b0;
    @(posedge clock);
    #1;
  endtask
  task automatic do_reset();
    reset = 1'b0;
    difftest_enable = 1'b0;
    tog = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    nb = 0;
    ntl = 0;
    ntl3 = 0;
  endtask
  task automatic drain();
    for (int i = 0; i < 400 && mq.size() != 0; i++) cyc(1'b0, '0);
    chk("drain_empty", mq.size(), 0);
    repeat (3) cyc(1'b0, '0);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [DW-1:0] ab;
    rows[0] = '{1, 0, 0, 2, 1, 0};
    rows[1] = '{3, 0, 0, 6, 3, 1};
    rows[2] = '{10, 6, 1, 20, 10, 3};
    rows[3] = '{4, 1, 0, 8, 4, 1};
    rows[4] = '{6, 0, 0, 12, 6, 2};
    do_reset();
    foreach (rows[r]) begin
      do_reset();
      rmode = rows[r].mode;
      for (int k = 0; k < rows[r].n; k++) begin
        cyc(1'b1, rand_word());
        repeat (rows[r].gap) cyc(1'b0, '0);
      end
      drain();
      chk("row_beats", nb, rows[r].beats);
      chk("row_tlast", ntl, rows[r].tl);
      chk("row_tlast3", ntl3, rows[r].tl3);
    end
    do_reset();
    rmode = 0;
    ab = {125{8'hAB}};
    cyc(1'b1, ab);
    cyc(1'b0, '0);
    chk("ab_b0_valid", tvalid, 1);
    chk("ab_b0_data", tdata, {64{8'hAB}});
    chk("ab_b0_keep", tkeep, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("ab_b0_last", tlast, 0);
    cyc(1'b0, '0);
    chk("ab_b1_data", tdata, {24'h0, {61{8'hAB}}});
    chk("ab_b1_keep", tkeep, 64'h1FFF_FFFF_FFFF_FFFF);
    chk("ab_b1_last", tlast, 1);
    cyc(1'b0, '0);
    chk("ab_done", tvalid, 0);
    do_reset();
    rmode = 3;
    for (int k = 0; k < 6; k++) cyc(1'b1, rand_word());
    chk("stall_cce_at6", cce, 1);
    cyc(1'b1, rand_word());
    chk("stall_cce_drop", cce, 0);
    cyc(1'b1, rand_word());
    chk("stall_no_ovf", ovf, 0);
    cyc(1'b1, rand_word());
    cyc(1'b0, '0);
    chk("stall_ovf", ovf, 1);
    chk("stall_drop1", drops, 1);
    rmode = 0;
    cyc(1'b0, '0);
    cyc(1'b1, rand_word());
    rmode = 3;
    cyc(1'b0, '0);
    chk("full_pushpop_nodrop", drops, 1);
    chk("full_cce", cce, 0);
    cyc(1'b1, rand_word());
    cyc(1'b0, '0);
    chk("full_still_full", drops, 2);
    rmode = 0;
    drain();
    do_reset();
    rmode = 3;
    cyc(1'b1, rand_word());
    cyc(1'b0, '0);
    cyc(1'b0, '0);
    chk("mid_valid", tvalid, 1);
    reset = 1'b0;
    #1;
    chk("mid_rst_valid", tvalid, 0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    rmode = 0;
    repeat (3) cyc(1'b0, '0);
    chk("post_rst_valid", tvalid, 0);
    chk("post_rst_cce", cce, 1);
    do_reset();
    rmode = 2;
    for (int i = 0; i < 1500; i++) cyc($urandom_range(0, 99) < (i < 750 ? 60 : 20), rand_word());
    rmode = 0;
    drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
